pic_frame_rx: RTL and testbench

//  Receive-side frame parser for picture upload over the WIFI UART link. Consumes bytes from uart_rx
//  (o_uart_data/o_rx_done), detects a sync header, unpacks 12-bit RGB pixels and drives a write port

---
 rtl/pic_frame_rx.sv | 129 ++++++++++++
 tb/tb_pic_frame_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pic_frame_rx.sv
// Receive-side frame parser: finds the sync header, unpacks 12-bit pixels into frame-buffer
// writes and checks the trailing 8-bit payload checksum.
module pic_frame_rx #(
   parameter int unsigned IMG_W       = 160,
   parameter int unsigned IMG_H       = 120,
   parameter int unsigned ADDR_WIDTH  = 15,
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter logic [7:0]  SYNC0       = 8'hA5,
   parameter logic [7:0]  SYNC1       = 8'h5A
) (
   input  logic                  i_clk_sys,
   input  logic                  i_rst_n,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [11:0]           o_wr_data,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_frame_err,
   output logic [7:0]            o_frame_cnt
);

   localparam int unsigned NPIX = IMG_W * IMG_H;
   localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
   localparam logic [TW-1:0]         TO_LAST   = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {StIdle, StSync, StPixHi, StPixLo, StCheck} state_e;

   state_e                state_q, state_d;
   logic [7:0]            sum_q, sum_d;
   logic [3:0]            hi_q, hi_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  timeout;

   logic                  wr_en_d, busy_d, done_d, err_d;
   logic [ADDR_WIDTH-1:0] wr_addr_d;
   logic [11:0]           wr_data_d;
   logic [7:0]            cnt_d;

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         sum_q        <= '0;
         hi_q         <= '0;
         addr_q       <= '0;
         tmo_q        <= '0;
         o_wr_en      <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         o_frame_cnt  <= '0;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         hi_q         <= hi_d;
         addr_q       <= addr_d;
         tmo_q        <= tmo_d;
         o_wr_en      <= wr_en_d;
         o_wr_addr    <= wr_addr_d;
         o_wr_data    <= wr_data_d;
         o_busy       <= busy_d;
         o_frame_done <= done_d;
         o_frame_err  <= err_d;
         o_frame_cnt  <= cnt_d;
      end
   end

   // A byte arriving on the expiry cycle suppresses the timeout.
   assign timeout = (state_q != StIdle) && !i_rx_done && (tmo_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      tmo_d   = (state_q == StIdle || i_rx_done) ? '0 : tmo_q + 1'b1;
      if (timeout) begin
         state_d = StIdle;
         tmo_d   = '0;
      end else if (i_rx_done) begin
         unique case (state_q)
            StIdle: begin
               if (i_rx_data == SYNC0) state_d = StSync;
            end
            StSync: begin
               if (i_rx_data == SYNC1) begin
                  state_d = StPixHi;
                  addr_d  = '0;
                  sum_d   = '0;
               end else if (i_rx_data != SYNC0) begin
                  state_d = StIdle;
               end
            end
            StPixHi: begin
               hi_d    = i_rx_data[3:0];
               sum_d   = sum_q + i_rx_data;
               state_d = StPixLo;
            end
            StPixLo: begin
               sum_d = sum_q + i_rx_data;
               if (addr_q == LAST_ADDR) begin
                  state_d = StCheck;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = StPixHi;
               end
            end
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      wr_en_d   = i_rx_done && !timeout && (state_q == StPixLo);
      wr_addr_d = wr_en_d ? addr_q : o_wr_addr;
      wr_data_d = wr_en_d ? {hi_q, i_rx_data} : o_wr_data;
      done_d    = i_rx_done && (state_q == StCheck) && (i_rx_data == sum_q);
      err_d     = timeout || (i_rx_done && (state_q == StCheck) && (i_rx_data != sum_q));
      busy_d    = (state_d != StIdle);
      cnt_d     = o_frame_cnt + 8'(done_d);
   end

endmodule

// File: tb/tb_pic_frame_rx.sv
// Bench for pic_frame_rx: directed frames plus random frames, gaps and checksum corruption,
// checked against expectations built from the frame definition.
module tb_pic_frame_rx;

   localparam int unsigned IMG_W = 2;
   localparam int unsigned IMG_H = 2;
   localparam int unsigned NPIX  = IMG_W * IMG_H;
   localparam int unsigned AW    = 2;
   localparam int unsigned TMO   = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_done = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [11:0]   wr_data;
   logic          busy, frame_done, frame_err;
   logic [7:0]    frame_cnt;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] cnt_exp = '0;
   logic [7:0] fr_hi[NPIX];
   logic [7:0] fr_lo[NPIX];

   pic_frame_rx #(
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .ADDR_WIDTH  (AW),
      .TIMEOUT_CYC (TMO),
      .SYNC0       (8'hA5),
      .SYNC1       (8'h5A)
   ) dut (
      .i_clk_sys    (clk),
      .i_rst_n      (rst_n),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .o_busy       (busy),
      .o_frame_done (frame_done),
      .o_frame_err  (frame_err),
      .o_frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the byte was taken.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_quiet", {29'd0, wr_en, frame_done, frame_err}, 32'd0);
      end
   endtask

   function automatic logic [7:0] frame_csum();
      int s = 0;
      for (int i = 0; i < NPIX; i++) s += int'(fr_hi[i]) + int'(fr_lo[i]);
      return 8'(s % 256);
   endfunction

   task automatic set_frame1();
      fr_hi[0] = 8'h01; fr_lo[0] = 8'h23;
      fr_hi[1] = 8'h04; fr_lo[1] = 8'h56;
      fr_hi[2] = 8'h07; fr_lo[2] = 8'h89;
      fr_hi[3] = 8'h0A; fr_lo[3] = 8'hBC;
   endtask

   // Sends header, payload and csum; the gap after payload byte slow_pos is slow_gap cycles.
   task automatic send_frame(input logic [7:0] csum, input int slow_pos, input int slow_gap,
                             input int max_gap);
      logic good;
      int   pos;
      good = (csum == frame_csum());
      pos  = 0;
      send_byte(8'hA5);
      check("busy_sync0", busy, 1);
      idle($urandom_range(max_gap, 0));
      send_byte(8'h5A);
      check("busy_sync1", busy, 1);
      idle($urandom_range(max_gap, 0));
      for (int i = 0; i < NPIX; i++) begin
         for (int h = 0; h < 2; h++) begin
            send_byte(h == 0 ? fr_hi[i] : fr_lo[i]);
            check("no_err_mid", {frame_err, frame_done}, 0);
            check("wr_en", wr_en, h);
            if (h == 1) begin
               check("wr_addr", wr_addr, i);
               check("wr_data", wr_data, {fr_hi[i][3:0], fr_lo[i]});
            end
            idle(pos == slow_pos ? slow_gap : $urandom_range(max_gap, 0));
            pos++;
         end
      end
      send_byte(csum);
      if (good) cnt_exp = cnt_exp + 8'd1;
      check("frame_done", frame_done, good);
      check("frame_err", frame_err, !good);
      check("frame_cnt", frame_cnt, cnt_exp);
      check("busy_end", busy, 0);
      check("addr_hold", wr_addr, NPIX - 1);
      check("data_hold", wr_data, {fr_hi[NPIX-1][3:0], fr_lo[NPIX-1]});
      @(negedge clk);
      check("pulse_width", {frame_done, frame_err}, 0);
   endtask

   initial begin
      int k;
      int goods;
      logic [7:0] start_cnt;
      logic [7:0] cs;

      repeat (3) @(negedge clk);
      check("reset_outs", {wr_en, 10'(wr_addr), wr_data, busy, frame_done, frame_err, frame_cnt},
            0);
      rst_n = 1'b1;
      @(negedge clk);

      // Good frame, then bad checksum.
      set_frame1();
      send_frame(8'hD4, -1, 0, 0);
      send_frame(8'hD5, -1, 0, 2);

      // Resync through junk and a repeated SYNC0.
      send_byte(8'h00);
      check("busy_junk", busy, 0);
      send_byte(8'hA5);
      send_frame(8'hD4, -1, 0, 1);
      send_byte(8'h00);
      send_byte(8'hA5);
      check("busy_a5", busy, 1);
      send_byte(8'h33);
      check("busy_abort", busy, 0);

      // Timeout after a stalled first payload byte.
      send_byte(8'hA5);
      send_byte(8'h5A);
      send_byte(8'h01);
      k = 0;
      while (!frame_err && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("tmo_latency", k, TMO);
      check("tmo_busy", busy, 0);
      check("tmo_no_done", frame_done, 0);
      check("tmo_cnt", frame_cnt, cnt_exp);
      @(negedge clk);
      check("tmo_pulse", frame_err, 0);
      send_frame(8'hD4, -1, 0, 1);

      // Reset mid-frame after two pixels.
      send_byte(8'hA5);
      send_byte(8'h5A);
      for (int i = 0; i < 2; i++) begin
         send_byte(fr_hi[i]);
         send_byte(fr_lo[i]);
      end
      rst_n = 1'b0;
      #1;
      check("rst_outs", {wr_en, 10'(wr_addr), wr_data, busy, frame_done, frame_err, frame_cnt}, 0);
      cnt_exp = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(8'hD4, -1, 0, 0);

      // Byte lands exactly on the would-be expiry cycle.
      send_frame(8'hD4, 0, TMO - 1, 0);

      // Random frames until 256 good ones have wrapped the counter.
      start_cnt = cnt_exp;
      goods = 0;
      for (int f = 0; f < 1000 && goods < 256; f++) begin
         for (int i = 0; i < NPIX; i++) begin
            fr_hi[i] = 8'($urandom);
            fr_lo[i] = 8'($urandom);
         end
         for (int j = $urandom_range(2, 0); j > 0; j--) begin
            cs = 8'($urandom);
            send_byte(cs == 8'h5A ? 8'h00 : cs);
         end
         cs = frame_csum();
         if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
         else goods++;
         send_frame(cs, $urandom_range(2 * NPIX - 1, 0), $urandom_range(TMO - 1, 0), 3);
      end
      check("cnt_wrap", frame_cnt, start_cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
